// File: rtl/ccc_stream_encoder.sv
// Streaming CCC encoder. Raster RGB pixels are collected into two 4-row band buffers.
// Each full band is encoded by LANES time-multiplexed 4x4 lanes, and the words leave in block order.

module ccc_encoder_4x4 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [383:0] rgb_data,
    output logic         done,
    output logic [63:0]  ccc_data
);
    // Word = {brightest pixel, darkest pixel, bitmap}. Bit i is set when pixel i has
    // luma (r+2g+b) at or above the block mean. Ties keep the lowest pixel index.
    logic [383:0] pix_q;
    logic         busy_q, done_q;
    logic [63:0]  ccc_q, ccc_d;
    logic [9:0]   lum [16];
    logic [9:0]   hi_lum, lo_lum;
    logic [23:0]  hi_px, lo_px;
    logic [13:0]  lum_sum;
    logic [15:0]  bitmap;

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        lum_sum = '0;
        bitmap  = '0;
        for (int i = 0; i < 16; i++) begin
            lum[i]  = {2'b00, pix_q[i*24+16 +: 8]} + {1'b0, pix_q[i*24+8 +: 8], 1'b0}
                    + {2'b00, pix_q[i*24 +: 8]};
            lum_sum = lum_sum + {4'b0000, lum[i]};
        end
        hi_lum = lum[0];
        lo_lum = lum[0];
        hi_px  = pix_q[23:0];
        lo_px  = pix_q[23:0];
        for (int i = 1; i < 16; i++) begin
            if (lum[i] > hi_lum) begin
                hi_lum = lum[i];
                hi_px  = pix_q[i*24 +: 24];
            end
            if (lum[i] < lo_lum) begin
                lo_lum = lum[i];
                lo_px  = pix_q[i*24 +: 24];
            end
        end
        for (int i = 0; i < 16; i++)
            bitmap[i] = {lum[i], 4'b0000} >= lum_sum;
        ccc_d = {hi_px, lo_px, bitmap};
    end

    // NOTE: sequential state uses non-blocking '<='; the blocking '=' above stays in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ccc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
            end else if (busy_q) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                ccc_q  <= ccc_d;
            end
        end
    end

    // NOTE: pure datapath storage has no reset. The control flags above decide when it is meaningful.
    always_ff @(posedge clk) begin
        if (start) pix_q <= rgb_data;
    end

    assign done     = done_q;
    assign ccc_data = ccc_q;
endmodule

module ccc_stream_encoder #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int LANES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        frame_done,
    output logic        sof_err
);
    localparam int GROUPS = WIDTH / (4 * LANES);
    localparam int BANDS  = HEIGHT / 4;
    localparam int CW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int BW = (BANDS > 1)  ? $clog2(BANDS)  : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int KW = (LANES > 1)  ? $clog2(LANES)  : 1;

    if (WIDTH % (4 * LANES) != 0) begin : g_bad_width
        $error("ccc_stream_encoder: WIDTH must be a multiple of 4*LANES");
    end
    if (HEIGHT % 4 != 0) begin : g_bad_height
        $error("ccc_stream_encoder: HEIGHT must be a multiple of 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_EMIT} state_e;

    logic [23:0]    band_buf_q [2][4][WIDTH];
    logic [CW-1:0]  col_q, wcol;
    logic [1:0]     brow_q, wrow;
    logic [BW-1:0]  band_q, enc_band_q;
    logic           wb_q, rb_q, sof_err_q;
    logic [1:0]     full_q, full_set, full_clr;
    logic           accept, restart, band_end;

    state_e         state_q;
    logic [GW-1:0]  g_q;
    logic [KW-1:0]  k_q;
    logic [LANES-1:0] done_lat_q, lane_done;
    logic [63:0]    lane_ccc [LANES];
    logic [63:0]    word_q [LANES];
    logic [383:0]   lane_rgb [LANES];
    logic           out_valid_q, out_last_q, frame_done_q;
    logic           lane_start, capture, xfer, last_group, last_band, group_end;

    // A mid-frame sof restarts the frame in place: the pixel lands at (0,0) of the same buffer.
    assign in_ready = !rst && !full_q[wb_q];
    assign accept   = in_valid && in_ready;
    assign restart  = in_sof && (col_q != '0 || brow_q != 2'd0 || band_q != '0);
    assign wcol     = restart ? '0 : col_q;
    assign wrow     = restart ? 2'd0 : brow_q;
    assign band_end = accept && wcol == CW'(WIDTH - 1) && wrow == 2'd3;
    assign full_set = band_end ? (2'b01 << wb_q) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            brow_q    <= 2'd0;
            band_q    <= '0;
            wb_q      <= 1'b0;
            sof_err_q <= 1'b0;
        end else if (accept) begin
            if (restart) sof_err_q <= 1'b1;
            if (band_end) begin
                col_q  <= '0;
                brow_q <= 2'd0;
                wb_q   <= !wb_q;
                band_q <= (band_q == BW'(BANDS - 1)) ? '0 : band_q + 1'b1;
            end else begin
                col_q  <= (wcol == CW'(WIDTH - 1)) ? '0 : wcol + 1'b1;
                brow_q <= (wcol == CW'(WIDTH - 1)) ? wrow + 2'd1 : wrow;
                if (restart) band_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) band_buf_q[wb_q][wrow][wcol] <= in_data;
    end

    // Set and clear always address different bands, so both apply in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) full_q <= 2'b00;
        else     full_q <= (full_q | full_set) & ~full_clr;
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_rgb[k] = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    lane_rgb[k][(r*4 + c)*24 +: 24] =
                        band_buf_q[rb_q][r][CW'((int'(g_q) * LANES + k) * 4 + c)];
        end
    end

    assign lane_start = state_q == S_START;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ccc_encoder_4x4 u_lane (
            .clk      (clk),
            .rst      (rst),
            .start    (lane_start),
            .rgb_data (lane_rgb[k]),
            .done     (lane_done[k]),
            .ccc_data (lane_ccc[k])
        );
    end

    assign xfer       = out_valid_q && out_ready;
    assign last_group = g_q == GW'(GROUPS - 1);
    assign last_band  = enc_band_q == BW'(BANDS - 1);
    assign group_end  = xfer && k_q == KW'(LANES - 1);
    assign full_clr   = (group_end && last_group) ? (2'b01 << rb_q) : 2'b00;
    assign capture    = state_q == S_WAIT && (&(done_lat_q | lane_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rb_q         <= 1'b0;
            g_q          <= '0;
            k_q          <= '0;
            enc_band_q   <= '0;
            done_lat_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (full_q[rb_q] || full_set[rb_q]) state_q <= S_START;
                S_START: begin
                    done_lat_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    done_lat_q <= done_lat_q | lane_done;
                    if (capture) begin
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (LANES == 1) && last_group && last_band;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: if (xfer) begin
                    if (k_q == KW'(LANES - 1)) begin
                        out_valid_q  <= 1'b0;
                        out_last_q   <= 1'b0;
                        frame_done_q <= out_last_q;
                        k_q          <= '0;
                        if (last_group) begin
                            g_q        <= '0;
                            rb_q       <= !rb_q;
                            enc_band_q <= last_band ? '0 : enc_band_q + 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            g_q     <= g_q + 1'b1;
                            state_q <= S_START;
                        end
                    end else begin
                        k_q        <= k_q + 1'b1;
                        out_last_q <= ((k_q + 1'b1) == KW'(LANES - 1)) && last_group && last_band;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            for (int k = 0; k < LANES; k++) word_q[k] <= lane_ccc[k];
    end

    assign out_valid  = !rst && out_valid_q;
    assign out_last   = !rst && out_last_q;
    assign frame_done = !rst && frame_done_q;
    assign sof_err    = !rst && sof_err_q;
    assign out_data   = out_valid ? word_q[k_q] : '0;
endmodule

// File: tb/tb_ccc_stream_encoder.sv
// Self-checking bench for ccc_stream_encoder. Randomised frames are compared against a
// frame-level reference model built from mean-luma block encoding.

module tb_ccc_stream_encoder;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [ND];
    logic        in_valid  [ND];
    logic        in_sof    [ND];
    logic        out_ready [ND];
    logic [23:0] in_data   [ND];
    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic        out_last  [ND];
    logic        frame_done[ND];
    logic        sof_err   [ND];
    logic [63:0] out_data  [ND];
    int          rdy_mode  [ND];

    ccc_stream_encoder #(.WIDTH(8), .HEIGHT(8), .LANES(2)) u_dut_l2 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_sof(in_sof[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .frame_done(frame_done[0]), .sof_err(sof_err[0]));

    ccc_stream_encoder #(.WIDTH(8), .HEIGHT(8), .LANES(1)) u_dut_l1 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_sof(in_sof[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .frame_done(frame_done[1]), .sof_err(sof_err[1]));

    ccc_stream_encoder #(.WIDTH(16), .HEIGHT(8), .LANES(1)) u_dut_w16 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_sof(in_sof[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
        .frame_done(frame_done[2]), .sof_err(sof_err[2]));

    // Output-ready policy per DUT: 0 stalled, 1 always ready, 2 random 50%.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < ND; d++)
            out_ready[d] = (rdy_mode[d] == 1) || (rdy_mode[d] == 2 && $urandom_range(1) == 1);
    end

    // Transfer monitor: records words, frame_done timing and hold-while-stalled violations.
    logic [64:0] got0 [$];
    logic [64:0] got1 [$];
    int          fd_cnt [ND];
    int          fd_ok  [ND];
    int          hold_err [ND];
    logic        stall_q [ND];
    logic        lastx_q [ND];
    logic [64:0] held_q  [ND];

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst[d]) begin
                stall_q[d] = 1'b0;
                lastx_q[d] = 1'b0;
            end else begin
                if (stall_q[d] && !(out_valid[d] && {out_last[d], out_data[d]} == held_q[d]))
                    hold_err[d]++;
                if (frame_done[d]) begin
                    fd_cnt[d]++;
                    if (lastx_q[d]) fd_ok[d]++;
                end
                lastx_q[d] = out_valid[d] && out_ready[d] && out_last[d];
                stall_q[d] = out_valid[d] && !out_ready[d];
                held_q[d]  = {out_last[d], out_data[d]};
                if (out_valid[d] && out_ready[d]) begin
                    if (d == 0)      got0.push_back({out_last[d], out_data[d]});
                    else if (d == 1) got1.push_back({out_last[d], out_data[d]});
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rd [ND];
    logic [23:0] frm [8][16];

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int avail(input int d);
        return ((d == 0) ? got0.size() : got1.size()) - rd[d];
    endfunction

    function automatic logic [64:0] qget(input int d, input int i);
        return (d == 0) ? got0[i] : got1[i];
    endfunction

    // Reference block: brightest/darkest pixel by r+2g+b plus an at-or-above-mean bitmap.
    function automatic logic [63:0] ref_block(input int bx, input int by);
        int          lum [16];
        int          sum = 0;
        int          hi = 0;
        int          lo = 0;
        logic [15:0] bm = '0;
        logic [23:0] p;
        for (int i = 0; i < 16; i++) begin
            p = frm[by*4 + i/4][bx*4 + i%4];
            lum[i] = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
            sum += lum[i];
        end
        for (int i = 0; i < 16; i++) begin
            if (lum[i] > lum[hi]) hi = i;
            if (lum[i] < lum[lo]) lo = i;
            bm[i] = (16 * lum[i] >= sum);
        end
        return {frm[by*4 + hi/4][bx*4 + hi%4], frm[by*4 + lo/4][bx*4 + lo%4], bm};
    endfunction

    task automatic fill(input int w, input int h, input int kind);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                case (kind)
                    0:       frm[y][x] = 24'hFF0000;
                    1:       frm[y][x] = 24'((x << 16) | (y << 8));
                    default: frm[y][x] = 24'($urandom());
                endcase
    endtask

    task automatic push_pixel(input int d, input logic [23:0] data, input logic sof);
        logic acc = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_sof[d]   = sof;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        in_sof[d]   = 1'b0;
        check("in_handshake", 65'(acc), 65'(1));
    endtask

    task automatic send_frame(input int d, input int w, input int h, input logic exp_sof);
        for (int i = 0; i < w*h; i++) begin
            push_pixel(d, frm[i/w][i%w], i == 0);
            if (i == 0) begin
                @(negedge clk);
                check("sof_err_after_first", 65'(sof_err[d]), 65'(exp_sof));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input int d, input int w, input int h, input logic exp_sof,
                             input string tag);
        int nb  = (w/4) * (h/4);
        int fd0 = fd_cnt[d];
        int ok0 = fd_ok[d];
        int waited = 0;
        send_frame(d, w, h, exp_sof);
        while (avail(d) < nb && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_word_count"}, 65'(avail(d)), 65'(nb));
        if (avail(d) >= nb)
            for (int b = 0; b < nb; b++)
                check({tag, "_word"}, qget(d, rd[d] + b),
                      {b == nb - 1, ref_block(b % (w/4), b / (w/4))});
        check({tag, "_frame_done_count"}, 65'(fd_cnt[d] - fd0), 65'(1));
        check({tag, "_frame_done_timing"}, 65'(fd_ok[d] - ok0), 65'(1));
        rd[d] += avail(d);
    endtask

    initial begin
        int base;
        int acc;
        for (int d = 0; d < ND; d++) begin
            rst[d]      = 1'b1;
            in_valid[d] = 1'b0;
            in_sof[d]   = 1'b0;
            in_data[d]  = '0;
            rdy_mode[d] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready",   65'(in_ready[0]),   65'(0));
        check("rst_out_valid",  65'(out_valid[0]),  65'(0));
        check("rst_out_last",   65'(out_last[0]),   65'(0));
        check("rst_frame_done", 65'(frame_done[0]), 65'(0));
        check("rst_sof_err",    65'(sof_err[0]),    65'(0));
        check("rst_out_data",   65'(out_data[0]),   65'(0));
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) check("post_rst_in_ready", 65'(in_ready[d]), 65'(1));
        @(posedge clk);
        #1;

        // Solid red frame, always ready
        rdy_mode[0] = 1;
        fill(8, 8, 0);
        base = got0.size();
        run_frame(0, 8, 8, 1'b0, "solid");
        if (got0.size() >= base + 4)
            for (int b = 0; b < 4; b++)
                check("solid_const", 65'(got0[base + b][63:0]), 65'(64'hFF0000_FF0000_FFFF));

        // Gradient frame, random backpressure
        rdy_mode[0] = 2;
        fill(8, 8, 1);
        run_frame(0, 8, 8, 1'b0, "gradient");

        // Mid-band sof: pixel 5 of band 0 restarts the frame
        fill(8, 8, 2);
        for (int i = 0; i < 5; i++) push_pixel(0, frm[0][i], i == 0);
        fill(8, 8, 2);
        run_frame(0, 8, 8, 1'b1, "sof_restart");

        // Reset while band 1 is in WAIT
        rdy_mode[0] = 1;
        fill(8, 8, 2);
        base = rd[0];
        send_frame(0, 8, 8, 1'b1);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk);
        check("midrst_in_ready",   65'(in_ready[0]),   65'(0));
        check("midrst_out_valid",  65'(out_valid[0]),  65'(0));
        check("midrst_out_last",   65'(out_last[0]),   65'(0));
        check("midrst_frame_done", 65'(frame_done[0]), 65'(0));
        check("midrst_sof_err",    65'(sof_err[0]),    65'(0));
        check("midrst_out_data",   65'(out_data[0]),   65'(0));
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", 65'(in_ready[0]), 65'(1));
        repeat (20) @(posedge clk);
        #1;
        check("midrst_words_before", 65'(avail(0)), 65'(2));
        if (avail(0) >= 2)
            for (int b = 0; b < 2; b++)
                check("midrst_band0_word", qget(0, base + b), {1'b0, ref_block(b, 0)});
        rd[0] += avail(0);
        fill(8, 8, 2);
        run_frame(0, 8, 8, 1'b0, "post_rst");

        // Same random frame through 2 lanes and 1 lane
        rdy_mode[0] = 2;
        rdy_mode[1] = 2;
        for (int f = 0; f < 2; f++) begin
            fill(8, 8, 2);
            run_frame(0, 8, 8, 1'b0, "lanes2");
            run_frame(1, 8, 8, 1'b0, "lanes1");
        end

        // Output fully stalled: two bands fill, then input stops
        acc = 0;
        in_valid[2] = 1'b1;
        for (int t = 0; t < 400; t++) begin
            in_data[2] = 24'($urandom());
            in_sof[2]  = (acc == 0);
            @(negedge clk);
            if (in_ready[2]) acc++;
            @(posedge clk);
            #1;
        end
        in_valid[2] = 1'b0;
        check("stall_accept_count", 65'(acc), 65'(128));
        @(negedge clk);
        check("stall_in_ready", 65'(in_ready[2]), 65'(0));
        check("stall_out_valid_held", 65'(out_valid[2]), 65'(1));

        check("hold_stable_l2", 65'(hold_err[0]), 65'(0));
        check("hold_stable_l1", 65'(hold_err[1]), 65'(0));
        check("hold_stable_w16", 65'(hold_err[2]), 65'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
